// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment display producer.
// Holds the segment code table, the largest displayable value, the
// encoder FSM state type and the packed four-digit BCD type.
package disp_pkg;

  localparam int MAX_DISP = 9999;

  // Segment codes are {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  typedef enum logic [1:0] {IDLE, CONV, ENCODE} state_t;

  // [3] thousands ... [0] units
  typedef logic [3:0][3:0] bcd4_t;

  // Non-decimal nibbles cannot occur after a clean conversion; they map to
  // a dash so a corrupted digit is visibly wrong rather than misleading.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    if (d <= 4'd9) seg_of = SEG_DIGIT[d];
    else           seg_of = SEG_DASH;
  endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble converter: one input bit per clock.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (control only)
//   start      : load bin and begin a conversion (only issued when idle)
//   bin        : binary value to convert
//   last       : high during the final shift cycle of a conversion
//   bcd        : four-digit BCD accumulator, valid once 'last' has passed
//   ovf        : sticky flag, value did not fit in four digits
module bin2bcd_iter
  import disp_pkg::*;
#(
  parameter int IN_W = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            last,
  output bcd4_t           bcd,
  output logic            ovf
);

  localparam int CNT_W = $clog2(IN_W);
  localparam logic [IN_W-1:0] MAX_V = IN_W'(MAX_DISP);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0]  shreg;
  logic [15:0]      adj;

  // Every nibble >= 5 gets +3 so the following left shift carries correctly.
  function automatic logic [15:0] add3(input bcd4_t b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++)
      r[i*4 +: 4] = (b[i] >= 4'd5) ? b[i] + 4'd3 : b[i];
    return r;
  endfunction

  assign adj  = add3(bcd);
  assign last = busy && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(IN_W - 1);
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

  // Datapath: load on start, then adjust-and-shift while busy.
  always_ff @(posedge clk) begin
    if (start) begin
      shreg <= bin;
      bcd   <= '0;
      ovf   <= (bin > MAX_V);
    end else if (busy) begin
      shreg <= {shreg[IN_W-2:0], 1'b0};
      bcd   <= {adj[14:0], shreg[IN_W-1]};
      ovf   <= ovf | adj[15];
    end
  end

endmodule

// File: rtl/freq_seg_encoder.sv
// Binary frequency value to packed four-digit seven-segment word.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bin_value  : binary value, taken when bin_valid && bin_ready
//   bin_valid  : bin_value is valid
//   bin_ready  : idle, next valid value will be accepted
//   seg_word   : [27:21] thousands .. [6:0] units segment codes
//   bcd_out    : {thou,hund,tens,units} BCD, saturated to 9999 on overflow
//   overflow   : last accepted value exceeded 9999
//   seg_valid  : one-cycle pulse when the three outputs above update
module freq_seg_encoder
  import disp_pkg::*;
#(
  parameter int IN_W     = 14,
  parameter int BLANK_LZ = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] bin_value,
  input  logic            bin_valid,
  output logic            bin_ready,
  output logic [27:0]     seg_word,
  output logic [15:0]     bcd_out,
  output logic            overflow,
  output logic            seg_valid
);

  state_t state, state_nx;
  logic   start, conv_last, enc_en, conv_ovf;
  bcd4_t  conv_bcd;

  // Leading zeros blank from the thousands digit down; units always shown.
  function automatic logic [27:0] encode(input bcd4_t b, input logic ov);
    logic [27:0] w;
    logic        lead;
    w = '0;
    if (ov) begin
      w = {4{SEG_DASH}};
    end else begin
      lead = (BLANK_LZ != 0);
      for (int i = 3; i >= 1; i--) begin
        lead = lead && (b[i] == 4'd0);
        w[i*7 +: 7] = lead ? SEG_BLANK : seg_of(b[i]);
      end
      w[6:0] = seg_of(b[0]);
    end
    return w;
  endfunction

  bin2bcd_iter #(.IN_W(IN_W)) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin_value),
    .last  (conv_last),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bin_valid) state_nx = CONV;
      CONV:    if (conv_last) state_nx = ENCODE;
      ENCODE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bin_ready = (state == IDLE);
    start     = bin_ready && bin_valid;
    enc_en    = (state == ENCODE);
  end

  // Encode stage: all display outputs change together on the seg_valid edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_valid <= 1'b0;
      seg_word  <= '0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      seg_valid <= enc_en;
      if (enc_en) begin
        seg_word <= encode(conv_bcd, conv_ovf);
        bcd_out  <= conv_ovf ? 16'h9999 : conv_bcd;
        overflow <= conv_ovf;
      end
    end
  end

endmodule
